// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   Consumer end of the EX/MEM pipeline register. Resolves beq/bne, drives the
//   PC redirect and a timed pipeline flush, and latches the MEM/WB register
//   (write-back data, destination register, RegWrite) together with the
//   architectural Remainder register written by Div. A retired-instruction
//   counter tracks every non-squashed instruction that does architectural work.
//
//   All state changes on the falling edge of Clk (pipeline writing phase);
//   the rising edge belongs to the surrounding read phase.
//
// Parameters
//   FLUSH_CYCLES  cycles FlushRegisters stays high per taken branch (>=1)
//   CNT_W         width of the retired-instruction counter
//
// Ports
//   Clk                   in   clock, state updates on negedge
//   Rst_n                 in   synchronous active-low reset, sampled on negedge
//   BranchTarget_in       in   branch target from EX/MEM
//   Zero_in               in   ALU zero flag from EX/MEM
//   ALU_Result_in         in   ALU result from EX/MEM
//   Remainder_in          in   divider remainder from EX/MEM
//   RegDst_Mux_Result_in  in   destination register from EX/MEM
//   RegWrite_in           in   control: write register file
//   WriteRemainder_in     in   control: write Remainder register (Div)
//   Branch_in             in   control: conditional branch
//   Bne_in                in   control: branch on not-equal (with Branch_in)
//   PCSrc                 out  combinational, 1 = load BranchTarget_out into PC
//   BranchTarget_out      out  combinational pass-through of BranchTarget_in
//   FlushRegisters        out  registered squash of IF/ID, ID/EX, EX/MEM
//   ALU_Result_out        out  MEM/WB write-back data
//   WriteReg_out          out  MEM/WB destination register
//   RegWrite_out          out  MEM/WB register-file write enable
//   Remainder_out         out  architectural Remainder register
//   RetireCount_out       out  count of retired (non-squashed) instructions
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [31:0]       BranchTarget_in,
  input  logic              Zero_in,
  input  logic [31:0]       ALU_Result_in,
  input  logic [31:0]       Remainder_in,
  input  logic [4:0]        RegDst_Mux_Result_in,
  input  logic              RegWrite_in,
  input  logic              WriteRemainder_in,
  input  logic              Branch_in,
  input  logic              Bne_in,
  output logic              PCSrc,
  output logic [31:0]       BranchTarget_out,
  output logic              FlushRegisters,
  output logic [31:0]       ALU_Result_out,
  output logic [4:0]        WriteReg_out,
  output logic              RegWrite_out,
  output logic [31:0]       Remainder_out,
  output logic [CNT_W-1:0]  RetireCount_out
);

  // state | meaning
  // ------+--------------------------------------------------------------
  // IDLE  | normal flow, EX/MEM slot is a real instruction
  // FLUSH | taken branch in flight, EX/MEM slot is a bubble; flush_cnt
  //       | counts down remaining flush periods, leaves at terminal 0

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Counter only has to hold FLUSH_CYCLES-1; keep at least one bit.
  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

  state_t          state;
  logic [FC_W-1:0] flush_cnt;

  logic squash;
  logic branch_cond;
  logic taken;
  logic dest_nonzero;
  logic rf_write;
  logic rem_write;
  logic retire;

  // ---------------------------------------------------------------------------
  // Slot qualification and branch resolution
  // ---------------------------------------------------------------------------
  always_comb begin
    squash       = (state == FLUSH);
    // beq takes on Zero, bne takes on ~Zero; Bne without Branch is inert.
    branch_cond  = Zero_in ^ Bne_in;
    taken        = Branch_in & branch_cond & ~squash;
    dest_nonzero = (RegDst_Mux_Result_in != 5'd0);
    // $zero is hard-wired, so writes to it are dropped here rather than in the RF.
    rf_write     = RegWrite_in & ~squash & dest_nonzero;
    rem_write    = WriteRemainder_in & ~squash;
    // A not-taken branch still retires; only bubbles are excluded.
    retire       = ~squash & (RegWrite_in | WriteRemainder_in | Branch_in);
  end

  assign PCSrc            = taken;
  assign BranchTarget_out = BranchTarget_in;

  // ---------------------------------------------------------------------------
  // Flush sequencer: down-counter with terminal-count compare
  // ---------------------------------------------------------------------------
  always_ff @(negedge Clk) begin
    if (!Rst_n) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      FlushRegisters <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (taken) begin
            state          <= FLUSH;
            flush_cnt      <= FLUSH_LOAD;
            FlushRegisters <= 1'b1;
          end
        end
        FLUSH: begin
          // Branches arriving here are already squashed through 'taken'.
          if (flush_cnt == '0) begin
            state          <= IDLE;
            FlushRegisters <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - FC_W'(1);
          end
        end
        default: begin
          state          <= IDLE;
          flush_cnt      <= '0;
          FlushRegisters <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // MEM/WB register
  // ---------------------------------------------------------------------------
  always_ff @(negedge Clk) begin
    if (!Rst_n) begin
      ALU_Result_out <= '0;
      WriteReg_out   <= '0;
      RegWrite_out   <= 1'b0;
    end else begin
      // Data and destination pass even for bubbles; only the enable is gated.
      ALU_Result_out <= ALU_Result_in;
      WriteReg_out   <= RegDst_Mux_Result_in;
      RegWrite_out   <= rf_write;
    end
  end

  // ---------------------------------------------------------------------------
  // Architectural Remainder register
  // ---------------------------------------------------------------------------
  always_ff @(negedge Clk) begin
    if (!Rst_n) begin
      Remainder_out <= '0;
    end else if (rem_write) begin
      Remainder_out <= Remainder_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Retired-instruction counter, wraps naturally at 2^CNT_W
  // ---------------------------------------------------------------------------
  always_ff @(negedge Clk) begin
    if (!Rst_n) begin
      RetireCount_out <= '0;
    end else if (retire) begin
      RetireCount_out <= RetireCount_out + CNT_W'(1);
    end
  end

endmodule
